// File: rtl/chip_checker_pkg.sv
// Shared types and pin maps for the 7400-series chip test sequencer.
// A 14-pin part sits in socket pins 1-7 and 10-16; socket pins 8 and 9 are NC.
package chip_checker_pkg;

  localparam int NUM_PINS = 16;
  localparam int VEC_W    = 8;

  typedef logic [NUM_PINS-1:0] pins_t;

  typedef enum logic [3:0] {
    CHIP_7400 = 4'd0,
    CHIP_7402 = 4'd1,
    CHIP_7404 = 4'd2,
    CHIP_7408 = 4'd3,
    CHIP_7432 = 4'd4,
    CHIP_7486 = 4'd5
  } chip_e;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE} state_e;

  function automatic logic chip_supported(logic [3:0] chip);
    return chip <= CHIP_7486;
  endfunction

  function automatic pins_t in_mask(logic [3:0] chip);
    pins_t m;
    case (chip)
      CHIP_7400, CHIP_7408, CHIP_7432, CHIP_7486: m = 16'h6C1B;
      CHIP_7402:                                  m = 16'h3636;
      CHIP_7404:                                  m = 16'h5415;
      default:                                    m = '0;
    endcase
    return m;
  endfunction

  function automatic pins_t out_mask(logic [3:0] chip);
    pins_t m;
    case (chip)
      CHIP_7400, CHIP_7408, CHIP_7432, CHIP_7486: m = 16'h1224;
      CHIP_7402:                                  m = 16'h4809;
      CHIP_7404:                                  m = 16'h2A2A;
      default:                                    m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] n_in(logic [3:0] chip);
    logic [3:0] n;
    case (chip)
      CHIP_7400, CHIP_7402, CHIP_7408, CHIP_7432, CHIP_7486: n = 4'd8;
      CHIP_7404:                                             n = 4'd6;
      default:                                               n = 4'd0;
    endcase
    return n;
  endfunction

  // Vector bit k lands on the k-th set bit of mask, counting from pin 1 upward.
  function automatic pins_t scatter(logic [VEC_W-1:0] vec, pins_t mask);
    pins_t      r;
    pins_t      vec_ext;
    logic [3:0] k;
    r       = '0;
    vec_ext = pins_t'(vec);
    k       = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      r[i] = mask[i] & vec_ext[k];
      k    = k + {3'b000, mask[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/chip_golden_model.sv
// Combinational reference behaviour of the supported chips, expressed on socket pins.
module chip_golden_model
  import chip_checker_pkg::*;
(
  input  logic [3:0] ChipSel,
  input  pins_t      PinOut,
  output pins_t      Expected
);

  function automatic logic gate2(logic [3:0] chip, logic a, logic b);
    logic y;
    case (chip)
      CHIP_7400: y = ~(a & b);
      CHIP_7408: y = a & b;
      CHIP_7432: y = a | b;
      CHIP_7486: y = a ^ b;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

  // Power and NC pins never feed a gate.
  logic unused_pins;
  assign unused_pins = ^{PinOut[15], PinOut[8:6]};

  always_comb begin
    // NOTE: default assignment first so every path drives every bit; no latch is inferred.
    Expected = '0;
    case (ChipSel)
      CHIP_7400, CHIP_7408, CHIP_7432, CHIP_7486: begin
        Expected[2]  = gate2(ChipSel, PinOut[0],  PinOut[1]);
        Expected[5]  = gate2(ChipSel, PinOut[3],  PinOut[4]);
        Expected[9]  = gate2(ChipSel, PinOut[10], PinOut[11]);
        Expected[12] = gate2(ChipSel, PinOut[13], PinOut[14]);
      end
      CHIP_7402: begin
        Expected[0]  = ~(PinOut[1]  | PinOut[2]);
        Expected[3]  = ~(PinOut[4]  | PinOut[5]);
        Expected[11] = ~(PinOut[9]  | PinOut[10]);
        Expected[14] = ~(PinOut[12] | PinOut[13]);
      end
      CHIP_7404: begin
        Expected[1]  = ~PinOut[0];
        Expected[3]  = ~PinOut[2];
        Expected[5]  = ~PinOut[4];
        Expected[9]  = ~PinOut[10];
        Expected[11] = ~PinOut[12];
        Expected[13] = ~PinOut[14];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/chip_test_sequencer.sv
// Exhaustive functional tester for a 7400-series part: drives every input vector,
// waits for settling, compares outputs with the golden model and reports the result.
module chip_test_sequencer
  import chip_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ChipSel,
  input  pins_t            PinIn,
  output pins_t            PinOut,
  output pins_t            PinOE,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic             Unsupported,
  output logic [ERR_W-1:0] ErrCount,
  output logic [VEC_W-1:0] FailVector,
  output pins_t            FailPins
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e           state_q;
  logic [3:0]       chip_q;
  logic [VEC_W-1:0] vec_q;
  logic [CNT_W-1:0] cnt_q;
  pins_t            pin_out_q, pin_oe_q, fail_pins_q;
  logic             busy_q, done_q, pass_q, unsup_q;
  logic [ERR_W-1:0] err_q;
  logic [VEC_W-1:0] fail_vec_q;

  pins_t            expected, diff;
  logic [VEC_W-1:0] last_vec;

  chip_golden_model u_golden (
    .ChipSel  (chip_q),
    .PinOut   (pin_out_q),
    .Expected (expected)
  );

  assign diff     = (PinIn ^ expected) & out_mask(chip_q);
  assign last_vec = VEC_W'((32'd1 << n_in(chip_q)) - 32'd1);

  always_ff @(posedge Clk) begin
    // NOTE: every register here is cleared by reset, including the result registers,
    // so no stale verdict survives an aborted test.
    if (Reset) begin
      state_q     <= IDLE;
      chip_q      <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      pin_out_q   <= '0;
      pin_oe_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      unsup_q     <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_pins_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so each branch sees pre-edge values of all state.
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            pin_oe_q  <= '0;
            pin_out_q <= '0;
            done_q    <= 1'b1;
            pass_q    <= ~unsup_q & (err_q == '0);
          end
          // The start action overrides the DONE holding values above.
          if (Start) begin
            chip_q      <= ChipSel;
            vec_q       <= '0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_pins_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            if (chip_supported(ChipSel)) begin
              unsup_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= APPLY;
            end else begin
              unsup_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        APPLY: begin
          pin_out_q <= scatter(vec_q, in_mask(chip_q));
          pin_oe_q  <= in_mask(chip_q);
          cnt_q     <= CNT_W'(SETTLE_CYCLES - 1);
          state_q   <= SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= SAMPLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        SAMPLE: begin
          if (diff != '0) begin
            if (err_q != '1) err_q <= err_q + 1'b1;
            // A zero count means this is the first mismatch of the run.
            if (err_q == '0) begin
              fail_vec_q  <= vec_q;
              fail_pins_q <= diff;
            end
          end
          state_q <= NEXT;
        end
        NEXT: begin
          if (vec_q == last_vec) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= APPLY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PinOut      = pin_out_q;
  assign PinOE       = pin_oe_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Pass        = pass_q;
  assign Unsupported = unsup_q;
  assign ErrCount    = err_q;
  assign FailVector  = fail_vec_q;
  assign FailPins    = fail_pins_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: a socket model plays the chip (with optional faults),
// a table of runs is scored through a queue, and two hand sequences cover reset aborts.
module tb_chip_test_sequencer;
  import chip_checker_pkg::*;

  typedef enum int {F_NONE, F_STUCK0, F_INV} fault_e;

  typedef struct {
    logic [3:0]  chip;
    fault_e      fault;
    int          err;
    int          fv;
    logic [15:0] fp;
    logic        pass;
    logic        unsup;
    int          lat;
  } run_t;

  // Gate pinouts in 14-pin chip numbering: A input, B input, Y output.
  localparam int QA [4] = '{1, 4, 9, 12};
  localparam int QB [4] = '{2, 5, 10, 13};
  localparam int QY [4] = '{3, 6, 8, 11};
  localparam int NA [4] = '{2, 5, 8, 11};
  localparam int NB [4] = '{3, 6, 9, 12};
  localparam int NY [4] = '{1, 4, 10, 13};
  localparam int IA [6] = '{1, 3, 5, 9, 11, 13};
  localparam int IY [6] = '{2, 4, 6, 8, 10, 12};

  logic        Clk = 1'b0;
  logic        Reset, Start;
  logic [3:0]  ChipSel;
  pins_t       PinIn, PinOut, PinOE, FailPins;
  logic        Busy, Done, Pass, Unsupported;
  logic [7:0]  ErrCount, FailVector;

  logic [3:0]  cur_chip;
  fault_e      cur_fault;
  int          n_vec = 0;
  int          n_bad = 0;
  int          pin_viol = 0;
  run_t        tbl [12];
  run_t        sb_q [$];

  always #5 Clk = ~Clk;

  chip_test_sequencer #(.SETTLE_CYCLES(4), .ERR_W(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ChipSel    (ChipSel),
    .PinIn      (PinIn),
    .PinOut     (PinOut),
    .PinOE      (PinOE),
    .Busy       (Busy),
    .Done       (Done),
    .Pass       (Pass),
    .Unsupported(Unsupported),
    .ErrCount   (ErrCount),
    .FailVector (FailVector),
    .FailPins   (FailPins)
  );

  function automatic int sb(int chip_pin);
    return (chip_pin <= 7) ? chip_pin - 1 : chip_pin + 1;
  endfunction

  function automatic pins_t tb_in_mask(logic [3:0] chip);
    pins_t m = '0;
    if (chip == 0 || chip == 3 || chip == 4 || chip == 5)
      for (int g = 0; g < 4; g++) begin m[sb(QA[g])] = 1'b1; m[sb(QB[g])] = 1'b1; end
    else if (chip == 1)
      for (int g = 0; g < 4; g++) begin m[sb(NA[g])] = 1'b1; m[sb(NB[g])] = 1'b1; end
    else if (chip == 2)
      for (int g = 0; g < 6; g++) m[sb(IA[g])] = 1'b1;
    return m;
  endfunction

  // What a real part (plus the chosen fault) would present on the socket.
  function automatic pins_t socket(logic [3:0] chip, pins_t drv, fault_e fault);
    pins_t r = 16'h0180;
    logic  a, b, y;
    r[sb(14)] = 1'b1;
    r[sb(7)]  = 1'b0;
    if (chip == 0 || chip == 3 || chip == 4 || chip == 5) begin
      for (int g = 0; g < 4; g++) begin
        a = drv[sb(QA[g])];
        b = drv[sb(QB[g])];
        case (chip)
          4'd0:    y = !(a && b);
          4'd3:    y = a && b;
          4'd4:    y = a || b;
          default: y = a != b;
        endcase
        r[sb(QY[g])] = (fault == F_INV) ? !y : y;
      end
    end else if (chip == 1) begin
      for (int g = 0; g < 4; g++) begin
        y = !(drv[sb(NA[g])] || drv[sb(NB[g])]);
        r[sb(NY[g])] = (fault == F_INV) ? !y : y;
      end
    end else if (chip == 2) begin
      for (int g = 0; g < 6; g++) begin
        y = !drv[sb(IA[g])];
        r[sb(IY[g])] = (fault == F_INV) ? !y : y;
      end
    end
    if (fault == F_STUCK0) r[sb(3)] = 1'b0;
    return r;
  endfunction

  always_comb PinIn = socket(cur_chip, PinOut, cur_fault);

  // Any drive on a non-input pin, or a drive value without its enable, is a violation.
  always @(negedge Clk)
    if (((PinOE & ~tb_in_mask(cur_chip)) != '0) || ((PinOut & ~PinOE) != '0))
      pin_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [3:0] chip, input fault_e fault);
    @(negedge Clk);
    cur_chip  = chip;
    cur_fault = fault;
    ChipSel   = chip;
    Start     = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start   = 1'b0;
    ChipSel = ~chip;
  endtask

  task automatic run_one(input int idx, input run_t v);
    run_t e;
    int   cyc;
    int   viol0;
    viol0 = pin_viol;
    sb_q.push_back(v);
    pulse_start(v.chip, v.fault);
    check($sformatf("run%0d done_cleared", idx), Done, 0);
    check($sformatf("run%0d busy", idx), Busy, !v.unsup);
    cyc = 0;
    while (!Done && cyc < 4000) begin
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
    end
    e = sb_q.pop_front();
    check($sformatf("run%0d latency", idx), cyc, e.lat);
    check($sformatf("run%0d err_count", idx), ErrCount, e.err);
    check($sformatf("run%0d fail_vector", idx), FailVector, e.fv);
    check($sformatf("run%0d fail_pins", idx), FailPins, e.fp);
    check($sformatf("run%0d pass", idx), Pass, e.pass);
    check($sformatf("run%0d unsupported", idx), Unsupported, e.unsup);
    repeat (3) @(negedge Clk);
    check($sformatf("run%0d done_held", idx), Done, 1);
    check($sformatf("run%0d oe_after", idx), PinOE, 0);
    check($sformatf("run%0d pin_safety", idx), pin_viol - viol0, 0);
  endtask

  initial begin
    tbl[0]  = '{4'd0,  F_NONE,   0,   0, 16'h0000, 1'b1, 1'b0, 1793};
    tbl[1]  = '{4'd0,  F_STUCK0, 192, 0, 16'h0004, 1'b0, 1'b0, 1793};
    tbl[2]  = '{4'd15, F_NONE,   0,   0, 16'h0000, 1'b0, 1'b1, 1};
    tbl[3]  = '{4'd0,  F_INV,    255, 0, 16'h1224, 1'b0, 1'b0, 1793};
    tbl[4]  = '{4'd1,  F_NONE,   0,   0, 16'h0000, 1'b1, 1'b0, 1793};
    tbl[5]  = '{4'd2,  F_NONE,   0,   0, 16'h0000, 1'b1, 1'b0, 449};
    tbl[6]  = '{4'd3,  F_STUCK0, 64,  3, 16'h0004, 1'b0, 1'b0, 1793};
    tbl[7]  = '{4'd4,  F_STUCK0, 192, 1, 16'h0004, 1'b0, 1'b0, 1793};
    tbl[8]  = '{4'd5,  F_NONE,   0,   0, 16'h0000, 1'b1, 1'b0, 1793};
    tbl[9]  = '{4'd1,  F_INV,    255, 0, 16'h4809, 1'b0, 1'b0, 1793};
    tbl[10] = '{4'd2,  F_INV,    64,  0, 16'h2A2A, 1'b0, 1'b0, 449};
    tbl[11] = '{4'd6,  F_STUCK0, 0,   0, 16'h0000, 1'b0, 1'b1, 1};

    Reset     = 1'b1;
    Start     = 1'b0;
    ChipSel   = 4'd0;
    cur_chip  = 4'd0;
    cur_fault = F_NONE;
    repeat (2) @(negedge Clk);
    check("reset pin_oe", PinOE, 0);
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset pass", Pass, 0);
    check("reset err_count", ErrCount, 0);
    check("reset unsupported", Unsupported, 0);
    Reset = 1'b0;

    // Abort a failing 7400 run after 100 clocks: 14 samples have landed by then.
    pulse_start(4'd0, F_INV);
    repeat (100) @(posedge Clk);
    @(negedge Clk);
    check("abort err_before_reset", ErrCount, 14);
    check("abort busy_before_reset", Busy, 1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("abort pin_oe", PinOE, 0);
    check("abort busy", Busy, 0);
    check("abort done", Done, 0);
    check("abort pass", Pass, 0);
    check("abort err_count", ErrCount, 0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) run_one(i, tbl[i]);

    // 7404 with a Start pulse at vector 10 (must be ignored) and Reset at vector 20.
    pulse_start(4'd2, F_INV);
    repeat (70) @(posedge Clk);
    @(negedge Clk);
    ChipSel = 4'd0;
    Start   = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    check("restart busy_kept", Busy, 1);
    repeat (69) @(posedge Clk);
    @(negedge Clk);
    check("restart err_count_kept", ErrCount, 20);
    check("restart pin_oe_7404", PinOE, 16'h5415);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    check("restart reset pin_oe", PinOE, 0);
    check("restart reset busy", Busy, 0);
    check("restart reset err_count", ErrCount, 0);
    repeat (10) @(negedge Clk);
    check("idle busy", Busy, 0);
    check("idle done", Done, 0);
    check("overall pin_safety", pin_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
